mips_branch_predictor: RTL



---
 rtl/mips_branch_predictor.sv | 113 +++++++++++
 1 files changed

// File: rtl/mips_branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters, looked up combinationally by fetch.
// MIPS_BP_TWO_BIT_EN selects 2-bit saturating counters; undefined gives 1-bit last-outcome bits.
module mips_branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int PC_WIDTH   = 32
) (
    input  logic                ClockPulse,
    input  logic                ResetN,
    input  logic [PC_WIDTH-1:0] LookupPc,
    output logic                Hit,
    output logic [PC_WIDTH-1:0] PredictedTarget,
    input  logic                UpdateValid,
    input  logic [PC_WIDTH-1:0] UpdatePc,
    input  logic                UpdateTaken,
    input  logic [PC_WIDTH-1:0] UpdateTarget,
    input  logic                InvalidateAll
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;
`ifdef MIPS_BP_TWO_BIT_EN
    localparam int              CTR_W     = 2;
    localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
`else
    localparam int              CTR_W     = 1;
    localparam logic [CTR_W-1:0] CTR_RESET = 1'b0;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
`endif

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic [PC_WIDTH-1:0] target_d [ENTRIES];
    logic [CTR_W-1:0]    ctr_q    [ENTRIES];
    logic [CTR_W-1:0]    ctr_d    [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  up_match;
    logic                  unused_pc_bits;

    assign lk_idx = LookupPc[INDEX_BITS+1:2];
    assign lk_tag = LookupPc[PC_WIDTH-1:INDEX_BITS+2];
    assign up_idx = UpdatePc[INDEX_BITS+1:2];
    assign up_tag = UpdatePc[PC_WIDTH-1:INDEX_BITS+2];
    // Byte offset within the instruction word never participates in lookup or training.
    assign unused_pc_bits = ^{LookupPc[1:0], UpdatePc[1:0]};

    // Reads the registered table only, so a same-cycle update is not bypassed.
    assign lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][CTR_W-1];
    assign Hit             = lk_hit;
    assign PredictedTarget = lk_hit ? target_q[lk_idx] : '0;

    assign up_match = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (InvalidateAll) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (UpdateValid) begin
            if (up_match) begin
                if (UpdateTaken) begin
                    target_d[up_idx] = UpdateTarget;
`ifdef MIPS_BP_TWO_BIT_EN
                    if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
`else
                    ctr_d[up_idx] = 1'b1;
`endif
                end else begin
`ifdef MIPS_BP_TWO_BIT_EN
                    if (ctr_q[up_idx] != 2'b00) ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
`else
                    ctr_d[up_idx] = 1'b0;
`endif
                end
            end else if (UpdateTaken) begin
                // Allocation evicts whatever branch currently owns this index.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = UpdateTarget;
                ctr_d[up_idx]    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge ClockPulse or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule
